vanilla_barrier_node: RTL and testbench

- Per-tile hardware barrier node that sits directly downstream of the machine CSR block.
- Consumes the barrier configuration (source mask, destination index) and the local barrier bit Pi from the CSR block.
- Combines Pi with neighbour link bits using C-element (all-agree) semantics, forwards the result toward the destination direction, and returns the barrier result Po to the CSR block.
- Includes the barrecv stall FSM for the core and a saturating wait-cycle counter for profiling.

---
 rtl/bsg_vanilla_pkg.sv | 17 +
 rtl/bsg_barrier_celement.sv | 27 ++
 rtl/vanilla_barrier_node.sv | 102 ++++++++++
 tb/tb_vanilla_barrier_node.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla-core types and constants.
// Barrier node FSM encoding and direction indices live here.
package bsg_vanilla_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } barrier_state_e;

   localparam int barrier_dir_p_idx_gp = 0;

   // Never returns 0 so a one-entry range still gets a 1-bit index.
   function automatic int safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_barrier_celement.sv
// All-agree combine: output follows the selected inputs only when they
// unanimously agree, otherwise it holds its current value.
module bsg_barrier_celement #(
   parameter int width_p = 7
) (
   input  logic [width_p-1:0] data_i,
   input  logic [width_p-1:0] mask_i,
   input  logic               out_i,
   output logic               out_o
);

   logic [width_p-1:0] sel;

   assign sel = data_i & mask_i;

   always_comb begin
      out_o = out_i;
      if (mask_i != '0) begin
         if (sel == mask_i) begin
            out_o = 1'b1;
         end else if (sel == '0) begin
            out_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/vanilla_barrier_node.sv
// Per-tile barrier node: combines Pi with neighbour links, forwards the
// result, returns Po to the CSR block and stalls barrecv until Po == Pi.
module vanilla_barrier_node
   import bsg_vanilla_pkg::*;
#(
   parameter int barrier_dirs_p     = 7,
   parameter int wait_ctr_width_p   = 16,
   localparam int barrier_lg_dirs_lp = safe_clog2(barrier_dirs_p + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [barrier_dirs_p-1:0]     barrier_src_r_i,
   input  logic [barrier_lg_dirs_lp-1:0] barrier_dest_r_i,
   input  logic                          barrier_pi_i,
   output logic                          barrier_po_o,
   input  logic [barrier_dirs_p-1:0]     link_data_i,
   output logic [barrier_dirs_p-1:0]     link_data_o,
   input  logic                          barrecv_i,
   output logic                          stall_barrier_o,
   output logic [wait_ctr_width_p-1:0]   wait_cycles_o
);

   localparam logic [barrier_dirs_p-1:0] p_mask_lp =
      barrier_dirs_p'(1) << barrier_dir_p_idx_gp;

   logic [barrier_dirs_p-1:0]   link_r;
   logic [barrier_dirs_p-1:0]   eff;
   logic [barrier_dirs_p-1:0]   dest_oh;
   logic                        out_r;
   logic                        out_n;
   logic                        po_r;
   logic                        po_link;
   logic                        root;
   logic                        mismatch;
   barrier_state_e              state_r;
   logic [wait_ctr_width_p-1:0] wait_r;

   // Slot P carries the live Pi; the link slots carry registered neighbours.
   assign eff = (link_r & ~p_mask_lp)
              | ({barrier_dirs_p{barrier_pi_i}} & p_mask_lp);

   bsg_barrier_celement #(
      .width_p(barrier_dirs_p)
   ) celem (
      .data_i(eff),
      .mask_i(barrier_src_r_i),
      .out_i (out_r),
      .out_o (out_n)
   );

   // Out-of-range destinations and P itself both make this node the root.
   always_comb begin
      root    = 1'b1;
      dest_oh = '0;
      po_link = 1'b0;
      for (int i = 1; i < barrier_dirs_p; i++) begin
         if (barrier_dest_r_i == barrier_lg_dirs_lp'(i)) begin
            root       = 1'b0;
            dest_oh[i] = 1'b1;
            po_link    = link_r[i];
         end
      end
   end

   assign link_data_o = dest_oh & {barrier_dirs_p{out_r}};
   assign barrier_po_o = po_r;
   assign mismatch = po_r ^ barrier_pi_i;
   assign wait_cycles_o = wait_r;

   assign stall_barrier_o = ~reset_i
      & ((state_r == WAIT)
      | ((state_r == IDLE) & barrecv_i & mismatch));

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         link_r <= '0;
         out_r  <= 1'b0;
         po_r   <= 1'b0;
      end else begin
         link_r <= link_data_i & ~p_mask_lp;
         out_r  <= out_n;
         po_r   <= root ? out_r : po_link;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= IDLE;
         wait_r  <= '0;
      end else begin
         unique case (state_r)
            IDLE: if (barrecv_i & mismatch) state_r <= WAIT;
            WAIT: if (!mismatch) state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
         if (stall_barrier_o && !(&wait_r)) begin
            wait_r <= wait_r + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vanilla_barrier_node.sv
// Randomized bench for vanilla_barrier_node against a behavioural model;
// a 4-bit-counter twin shares the stimulus to exercise saturation.
module tb_vanilla_barrier_node;

   localparam int D  = 7;
   localparam int LG = 3;

   logic          clk = 1'b0;
   logic          reset_i;
   logic [D-1:0]  src;
   logic [LG-1:0] dest;
   logic          pi;
   logic          barrecv;
   logic [D-1:0]  link_in;
   logic          po, po4;
   logic [D-1:0]  link_o, link_o4;
   logic          stall, stall4;
   logic [15:0]   wc;
   logic [3:0]    wc4;

   always #5 clk = ~clk;

   vanilla_barrier_node #(
      .barrier_dirs_p(D),
      .wait_ctr_width_p(16)
   ) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .barrier_src_r_i(src),
      .barrier_dest_r_i(dest),
      .barrier_pi_i(pi),
      .barrier_po_o(po),
      .link_data_i(link_in),
      .link_data_o(link_o),
      .barrecv_i(barrecv),
      .stall_barrier_o(stall),
      .wait_cycles_o(wc)
   );

   vanilla_barrier_node #(
      .barrier_dirs_p(D),
      .wait_ctr_width_p(4)
   ) dut4 (
      .clk_i(clk),
      .reset_i(reset_i),
      .barrier_src_r_i(src),
      .barrier_dest_r_i(dest),
      .barrier_pi_i(pi),
      .barrier_po_o(po4),
      .link_data_i(link_in),
      .link_data_o(link_o4),
      .barrecv_i(barrecv),
      .stall_barrier_o(stall4),
      .wait_cycles_o(wc4)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model state
   logic [D-1:0] m_link = '0;
   bit           m_out  = 0;
   bit           m_po   = 0;
   bit           m_wait = 0;
   int           m_cnt  = 0;

   task automatic step();
      bit           root, exp_stall, n_out, n_po, n_wait;
      logic [D-1:0] one, exp_link, eff, sel;
      int           c16, c4;
      #1;
      one  = 1;
      root = (dest == 0) || (int'(dest) >= D);
      exp_link  = (!root && m_out) ? (one << dest) : '0;
      exp_stall = !reset_i && (m_wait || (barrecv && (m_po != pi)));
      c16 = (m_cnt > 65535) ? 65535 : m_cnt;
      c4  = (m_cnt > 15) ? 15 : m_cnt;
      check("po", 32'(po), 32'(m_po));
      check("po4", 32'(po4), 32'(m_po));
      check("link_o", 32'(link_o), 32'(exp_link));
      check("link_o4", 32'(link_o4), 32'(exp_link));
      check("stall", 32'(stall), 32'(exp_stall));
      check("stall4", 32'(stall4), 32'(exp_stall));
      check("wait16", 32'(wc), c16);
      check("wait4", 32'(wc4), c4);
      if (reset_i) begin
         m_link = '0;
         m_out  = 0;
         m_po   = 0;
         m_wait = 0;
         m_cnt  = 0;
      end else begin
         eff = {m_link[D-1:1], pi};
         sel = eff & src;
         n_out = m_out;
         if (src != 0) begin
            if ($countones(sel) == $countones(src)) n_out = 1;
            else if ($countones(sel) == 0) n_out = 0;
         end
         n_po   = root ? m_out : m_link[dest];
         n_wait = m_wait ? (m_po != pi) : (barrecv && (m_po != pi));
         if (exp_stall) m_cnt++;
         m_out  = n_out;
         m_po   = n_po;
         m_wait = n_wait;
         m_link = {link_in[D-1:1], 1'b0};
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      reset_i = 1'b1;
      src     = '0;
      dest    = '0;
      pi      = 1'b0;
      barrecv = 1'b0;
      link_in = '0;
      @(posedge clk);
      @(negedge clk);
      run(2);
      reset_i = 1'b0;

      // single-tile root, barrecv alongside the Pi toggle
      src = 7'b0000001;
      run(2);
      pi = 1'b1;
      barrecv = 1'b1;
      run(1);
      barrecv = 1'b0;
      run(4);
      check("root_po_high", 32'(po), 32'd1);

      // three-source gather
      src = 7'b0000111;
      link_in = 7'b0000010;
      run(4);
      link_in = 7'b0000110;
      run(3);
      link_in = 7'b0000100;
      run(3);
      check("gather_hold", 32'(po), 32'd1);

      // non-root forward toward direction 3
      dest = 3'd3;
      link_in = 7'b0001000;
      run(4);
      check("fwd_link", 32'(link_o), 32'b0001000);

      // barrecv with Po == Pi == 0 never stalls
      reset_i = 1'b1;
      run(1);
      reset_i = 1'b0;
      src = '0;
      dest = '0;
      pi = 1'b0;
      link_in = '0;
      barrecv = 1'b1;
      run(3);
      check("nostall_cnt", 32'(wc), 32'd0);

      // held mismatch saturates the 4-bit counter
      pi = 1'b1;
      run(22);
      check("sat4", 32'(wc4), 32'd15);
      check("sat16", 32'(wc), 32'd22);

      // reset while waiting
      reset_i = 1'b1;
      run(1);
      reset_i = 1'b0;
      barrecv = 1'b0;
      run(1);
      check("rst_cnt", 32'(wc), 32'd0);

      for (int i = 0; i < 800; i++) begin
         reset_i = ($urandom_range(0, 149) == 0);
         if ($urandom_range(0, 15) == 0) begin
            src  = D'($urandom_range(0, 127));
            dest = LG'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 7) == 0) pi = ~pi;
         if ($urandom_range(0, 3) == 0) link_in = D'($urandom);
         barrecv = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
